dbus_uart_tx: RTL and testbench



---
 rtl/bus_pkg.sv | 5 +
 rtl/uart_pkg.sv | 15 +
 rtl/sync_fifo.sv | 44 ++++
 rtl/dbus_uart_tx.sv | 180 ++++++++++++++++++
 tb/tb_dbus_uart_tx.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared D-bus transfer encodings used by every slave on the interconnect.
package bus_pkg;
  typedef enum logic {READ = 1'b0, WRITE = 1'b1} ttype_t;
  typedef enum logic [1:0] {BYTE = 2'd0, HALFWORD = 2'd1, WORD = 2'd2} tsize_t;
endpackage

// File: rtl/uart_pkg.sv
// UART register map, status bit positions and transmitter state encoding.
package uart_pkg;
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int ST_READY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_BUSY  = 3;
  localparam int ST_OVF   = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/dbus_uart_tx.sv
// D-bus slave UART transmitter: register decode, baud engine and 8N1 serialiser fed from a byte FIFO.
module dbus_uart_tx #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ss,
  input  logic        bstart,
  input  logic [31:0] addr,
  input  logic        ttype,
  input  logic [1:0]  tsize,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        bdone,
  output logic        txd,
  output logic        irq
);
  import bus_pkg::*;
  import uart_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic        acc, is_wr, wr_en, fifo_push, fifo_pop;
  logic        fifo_full, fifo_empty, busy, tick;
  logic [1:0]  reg_sel;
  logic [7:0]  fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic [31:0] rd_val;

  logic        bdone_q, ie_q, ovf_q, irq_q;
  logic [31:0] rdata_q;
  logic [15:0] div_q;

  tx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;

  logic unused_bits;
  assign unused_bits = ^{addr[31:4], addr[1:0], tsize, wdata[31:16], fifo_count};

  assign acc       = bstart && ss;
  assign is_wr     = (ttype_t'(ttype) == WRITE);
  assign wr_en     = acc && is_wr;
  assign reg_sel   = addr[3:2];
  assign fifo_push = wr_en && (reg_sel == REG_TXDATA);
  assign tick      = (cnt_q == 16'd0);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (wdata[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_STATUS: begin
        rd_val[ST_READY] = !fifo_full;
        rd_val[ST_FULL]  = fifo_full;
        rd_val[ST_EMPTY] = fifo_empty;
        rd_val[ST_BUSY]  = busy;
        rd_val[ST_OVF]   = ovf_q;
      end
      REG_BAUDDIV: rd_val[15:0] = div_q;
      REG_CTRL:    rd_val[0]    = ie_q;
      default:     rd_val       = '0;
    endcase
  end

  // Every accepted transfer completes on the following cycle; writes take effect at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bdone_q <= 1'b0;
      rdata_q <= '0;
      div_q   <= DEFAULT_DIV;
      ie_q    <= 1'b0;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      bdone_q <= acc;
      rdata_q <= (acc && !is_wr) ? rd_val : '0;
      if (wr_en && reg_sel == REG_BAUDDIV) div_q <= wdata[15:0];
      if (wr_en && reg_sel == REG_CTRL)    ie_q  <= wdata[0];
      if (fifo_push && fifo_full && !fifo_pop)
        ovf_q <= 1'b1;
      else if (wr_en && reg_sel == REG_STATUS && wdata[ST_OVF])
        ovf_q <= 1'b0;
      irq_q <= ie_q && fifo_empty && !busy;
    end
  end

  assign bdone = bdone_q;
  assign rdata = rdata_q;
  assign irq   = irq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
    end
  end

  // The divisor is sampled only on counter reload, so BAUDDIV writes never stretch a bit in flight.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          cnt_d    = div_q;
          state_d  = START;
        end
      end
      START: begin
        if (tick) begin
          cnt_d   = div_q;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d   = div_q;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (tick) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            cnt_d    = div_q;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    txd  = 1'b1;
    busy = (state_q != IDLE);
    case (state_q)
      START:   txd = 1'b0;
      DATA:    txd = shift_q[0];
      default: txd = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_dbus_uart_tx.sv
// Bench for dbus_uart_tx: register vectors, a line-level UART receiver model and directed frame sequences.
module tb_dbus_uart_tx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ss = 1'b0, bstart = 1'b0, ttype = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [1:0]  tsize = 2'd2;
  logic [31:0] rdata;
  logic        bdone, txd, irq;

  int n_tests = 0;
  int n_fail  = 0;

  dbus_uart_tx dut (
    .clk(clk), .rst(rst), .ss(ss), .bstart(bstart), .addr(addr), .ttype(ttype),
    .tsize(tsize), .wdata(wdata), .rdata(rdata), .bdone(bdone), .txd(txd), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Receiver model: decodes 8N1 from the line using the currently programmed divisor and
  // demands that every cycle of each bit period holds the same level.
  int          rx_div = 867;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  longint      start_q[$];
  longint      cyc = 0;
  int          rx_bad = 0;
  logic [9:0]  rx_bits;
  bit          rx_err, rx_abort;
  int          rx_per;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && txd === 1'b0) begin
        rx_per = rx_div + 1;
        start_q.push_back(cyc);
        rx_err = 0;
        rx_abort = 0;
        for (int b = 0; b < 10 && !rx_abort; b++) begin
          for (int c = 0; c < rx_per && !rx_abort; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (rst) rx_abort = 1;
            else if (c == 0) rx_bits[b] = txd;
            else if (txd !== rx_bits[b]) rx_err = 1;
          end
        end
        if (!rx_abort) begin
          if (rx_err || rx_bits[0] !== 1'b0 || rx_bits[9] !== 1'b1) rx_bad++;
          rx_q.push_back(rx_bits[8:1]);
        end
      end
    end
  end

  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                     output logic [31:0] r);
    @(negedge clk);
    ss = 1'b1; bstart = 1'b1; addr = a; ttype = w; wdata = d;
    tsize = 2'($urandom_range(0, 2));
    @(posedge clk);
    #1;
    ss = 1'b0; bstart = 1'b0;
    check("bdone", {31'b0, bdone}, 32'd1);
    r = rdata;
    if (w && a[3:2] == 2'd2) rx_div = int'(d[15:0]);
  endtask

  task automatic tx_byte(input logic [7:0] b);
    logic [31:0] r;
    bus(32'h0, 1'b1, {24'hFFFFFF, b}, r);
    exp_q.push_back(b);
  endtask

  task automatic drain(input int budget, input string nm);
    int t;
    t = 0;
    while (rx_q.size() < exp_q.size() && t < budget) begin
      @(negedge clk);
      t++;
    end
    check({nm, " frame count"}, rx_q.size(), exp_q.size());
    while (exp_q.size() > 0 && rx_q.size() > 0)
      check({nm, " byte"}, {24'b0, rx_q.pop_front()}, {24'b0, exp_q.pop_front()});
    exp_q.delete();
    rx_q.delete();
    check({nm, " framing"}, rx_bad, 0);
    rx_bad = 0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[12];

  initial begin
    logic [31:0] r;
    int          t, bad, n, mdl_div;

    tbl[0]  = '{32'h0000_0004, 1'b0, 32'h0,         32'h0000_0005};
    tbl[1]  = '{32'h0000_0008, 1'b0, 32'h0,         32'h0000_0363};
    tbl[2]  = '{32'h0000_000C, 1'b0, 32'h0,         32'h0000_0000};
    tbl[3]  = '{32'h0000_0000, 1'b0, 32'h0,         32'h0000_0000};
    tbl[4]  = '{32'hABCD_0008, 1'b1, 32'hFFFF_1234, 32'h0000_0000};
    tbl[5]  = '{32'h0000_000B, 1'b0, 32'h0,         32'h0000_1234};
    tbl[6]  = '{32'h0000_000C, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[7]  = '{32'h0000_000C, 1'b0, 32'h0,         32'h0000_0001};
    tbl[8]  = '{32'h0000_000C, 1'b1, 32'hFFFF_FFFE, 32'h0000_0000};
    tbl[9]  = '{32'h0000_000C, 1'b0, 32'h0,         32'h0000_0000};
    tbl[10] = '{32'h0000_0004, 1'b1, 32'h0000_0010, 32'h0000_0000};
    tbl[11] = '{32'h0000_0004, 1'b0, 32'h0,         32'h0000_0005};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset txd", {31'b0, txd}, 32'd1);
    check("reset bdone", {31'b0, bdone}, 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset irq", {31'b0, irq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Unselected strobe is ignored
    @(negedge clk);
    bstart = 1'b1; ss = 1'b0; addr = 32'h4; ttype = 1'b0;
    @(posedge clk);
    #1;
    bstart = 1'b0;
    @(posedge clk);
    #1;
    check("no-ss bdone", {31'b0, bdone}, 32'd0);

    // Back-to-back: bstart held through the bdone cycle starts a second transfer
    @(negedge clk);
    ss = 1'b1; bstart = 1'b1; addr = 32'h4; ttype = 1'b0;
    @(posedge clk);
    #1;
    check("b2b first bdone", {31'b0, bdone}, 32'd1);
    check("b2b first rdata", rdata, 32'h5);
    addr = 32'h8;
    @(posedge clk);
    #1;
    check("b2b second bdone", {31'b0, bdone}, 32'd1);
    check("b2b second rdata", rdata, 32'h363);
    ss = 1'b0; bstart = 1'b0;
    @(posedge clk);
    #1;
    check("b2b idle bdone", {31'b0, bdone}, 32'd0);
    check("b2b idle rdata", rdata, 32'd0);

    for (int i = 0; i < 12; i++) begin
      bus(tbl[i].addr, tbl[i].wr, tbl[i].wdata, r);
      check($sformatf("vec%0d rdata", i), r, tbl[i].exp);
    end

    // Single frame at div=3: 40 cycles, LSB first
    bus(32'h8, 1'b1, 32'd3, r);
    start_q.delete();
    tx_byte(8'hA5);
    drain(200, "A5");
    check("A5 frames started", start_q.size(), 1);

    // Three contiguous frames at div=1
    bus(32'h8, 1'b1, 32'd1, r);
    start_q.delete();
    tx_byte(8'h41);
    tx_byte(8'h42);
    tx_byte(8'h43);
    drain(200, "ABC");
    bus(32'h4, 1'b0, 32'h0, r);
    check("ABC status drained", r, 32'h5);
    if (start_q.size() == 3) begin
      check("ABC gap 1", 32'(start_q[1] - start_q[0]), 32'd20);
      check("ABC gap 2", 32'(start_q[2] - start_q[1]), 32'd20);
    end else begin
      check("ABC frames started", start_q.size(), 3);
    end

    // Overflow: one in the shifter, eight queued, tenth dropped
    bus(32'h8, 1'b1, 32'd100, r);
    for (int i = 0; i < 10; i++) begin
      if (i < 9) tx_byte(8'(8'h10 + i));
      else bus(32'h0, 1'b1, 32'h0000_00EE, r);
    end
    bus(32'h4, 1'b0, 32'h0, r);
    check("ovf status", r, 32'h1A);
    bus(32'h4, 1'b1, 32'h10, r);
    bus(32'h4, 1'b0, 32'h0, r);
    check("ovf cleared status", r, 32'h0A);
    drain(9500, "ovf");
    bus(32'h4, 1'b0, 32'h0, r);
    check("ovf drained status", r, 32'h5);

    // Interrupt on drain
    bus(32'h8, 1'b1, 32'd0, r);
    bus(32'hC, 1'b1, 32'd1, r);
    tx_byte(8'h5A);
    @(posedge clk);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (irq !== 1'b0) bad++;
    end
    check("irq low during frame", bad, 0);
    t = 0;
    while (rx_q.size() < 1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    while (irq !== 1'b1 && t < 3) begin
      @(negedge clk);
      t++;
    end
    check("irq after drain", {31'b0, irq}, 32'd1);
    tx_byte(8'hC9);
    t = 0;
    while (irq !== 1'b0 && t < 3) begin
      @(negedge clk);
      t++;
    end
    check("irq cleared by write", {31'b0, irq}, 32'd0);
    drain(100, "irq");
    bus(32'hC, 1'b1, 32'd0, r);

    // Randomised bursts against the receiver model
    mdl_div = 0;
    for (int round = 0; round < 5; round++) begin
      mdl_div = $urandom_range(0, 4);
      bus(32'h8, 1'b1, 32'(mdl_div), r);
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        tx_byte(8'($urandom));
        if ($urandom_range(0, 1) == 1) begin
          bus({$urandom, 4'b0} | 32'h8 | 32'($urandom_range(0, 3)), 1'b0, 32'h0, r);
          check("rand bauddiv", r, 32'(mdl_div));
        end
        if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 20)) @(posedge clk);
      end
      drain(n * 10 * (mdl_div + 1) + 100, "rand");
      bus(32'h4, 1'b0, 32'h0, r);
      check("rand status", r, 32'h5);
    end

    // Reset in the middle of a data bit
    bus(32'h8, 1'b1, 32'd3, r);
    bus(32'h0, 1'b1, 32'h0000_00C3, r);
    t = 0;
    while (txd !== 1'b0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (13) @(posedge clk);
    #2;
    check("pre-reset txd", {31'b0, txd}, 32'd0);
    rst = 1'b1;
    #1;
    check("async reset txd", {31'b0, txd}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx_div = 867;
    rx_q.delete();
    bus(32'h4, 1'b0, 32'h0, r);
    check("post-reset status", r, 32'h5);
    bus(32'h8, 1'b0, 32'h0, r);
    check("post-reset bauddiv", r, 32'h363);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    check("post-reset line idle", bad, 0);
    check("post-reset no frame", rx_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
